// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel switch debouncer.
//   - 3-bit state encoding shared by both response modes
//   - mode selectors (early / delayed)
//   - width of the per-channel tick counter
//   - db_level(): the debounced output level held in each state
package debounce_pkg;

  typedef logic [2:0] state_t;

  // The counting states share an encoding between modes; only their
  // db level and their reaction to the synchronised input differ.
  localparam state_t ZERO      = 3'd0;
  localparam state_t RISE_LOCK = 3'd1;
  localparam state_t RISE_WAIT = 3'd1;
  localparam state_t ONE       = 3'd2;
  localparam state_t FALL_LOCK = 3'd3;
  localparam state_t FALL_WAIT = 3'd3;

  localparam int MODE_EARLY   = 0;
  localparam int MODE_DELAYED = 1;

  localparam int CNT_W = 4;

  // Early mode shows the new level during the lockout; delayed mode keeps
  // the old level until the input has proven stable. Illegal codes read 0.
  function automatic logic db_level(input state_t st, input int mode);
    logic lvl;
    case (st)
      RISE_LOCK: lvl = (mode == MODE_EARLY);
      ONE:       lvl = 1'b1;
      FALL_LOCK: lvl = (mode == MODE_DELAYED);
      default:   lvl = 1'b0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: two-flop synchroniser, debounce FSM, tick counter
// and registered outputs.
// Ports:
//   clk     system clock
//   reset_n asynchronous active-low reset
//   sw      raw asynchronous switch input
//   m_tick  shared one-cycle tick strobe
//   db      debounced level (registered)
//   rise    one-cycle pulse on db 0->1 (registered)
//   fall    one-cycle pulse on db 1->0 (registered)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int MODE    = MODE_EARLY,
  parameter int N_TICKS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  input  logic m_tick,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TICKS - 1);

  logic             s_p0;
  logic             s_p1;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             tick_done;
  logic             db_cur;
  logic             db_next;
  logic             rise_next;
  logic             fall_next;

  assign tick_done = m_tick && (cnt == CNT_LAST);

  // Stage p0/p1: synchroniser; then FSM state, tick counter and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_p0  <= 1'b0;
      s_p1  <= 1'b0;
      state <= ZERO;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s_p0  <= sw;
      s_p1  <= s_p0;
      state <= state_next;
      // Any state change restarts the count, so a tick landing on the
      // entry cycle of a counting state (or on an abort) is discarded.
      if (state_next != state) begin
        cnt <= '0;
      end else if (m_tick && ((state == RISE_LOCK) || (state == FALL_LOCK))) begin
        cnt <= cnt + CNT_W'(1);
      end
      db    <= db_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ZERO: begin
        if (s_p1) state_next = RISE_LOCK;
      end
      RISE_LOCK: begin
        // In delayed mode an input drop aborts, and outranks a tick.
        if ((MODE == MODE_DELAYED) && !s_p1) state_next = ZERO;
        else if (tick_done)                  state_next = ONE;
      end
      ONE: begin
        if (!s_p1) state_next = FALL_LOCK;
      end
      FALL_LOCK: begin
        if ((MODE == MODE_DELAYED) && s_p1) state_next = ONE;
        else if (tick_done)                 state_next = ZERO;
      end
      default: state_next = ZERO;
    endcase
  end

  // Outputs are decoded from next vs current state so the pulse lands in
  // the first cycle of the new db level.
  always_comb begin
    db_cur    = db_level(state, MODE);
    db_next   = db_level(state_next, MODE);
    rise_next = db_next & ~db_cur;
    fall_next = ~db_next & db_cur;
  end

endmodule

// File: rtl/multi_debouncer_fsm.sv
// N-channel switch debouncer with a shared free-running tick generator.
// Ports:
//   clk     system clock
//   reset_n asynchronous active-low reset
//   sw      raw asynchronous switch inputs, one per channel
//   db      debounced levels (registered)
//   rise    one-cycle pulses on db 0->1
//   fall    one-cycle pulses on db 1->0
module multi_debouncer_fsm
  import debounce_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int TICK_BITS = 19,
  parameter int N_TICKS   = 3,
  parameter int MODE      = MODE_EARLY
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  logic [TICK_BITS-1:0] q;
  logic                 m_tick;

  // Tick generator: wraps every 2^TICK_BITS cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= q + TICK_BITS'(1);
    end
  end

  assign m_tick = &q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .MODE    (MODE),
      .N_TICKS (N_TICKS)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .sw      (sw[i]),
      .m_tick  (m_tick),
      .db      (db[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer_fsm.sv
// Bench for multi_debouncer_fsm: one early-mode and one delayed-mode instance
// with a 16-cycle tick. Expected edge pulses are queued with the stimulus and
// popped by a monitor on every observed pulse.
module tb_multi_debouncer_fsm;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N_CH-1:0] sw_e, db_e, rise_e, fall_e;
  logic [N_CH-1:0] sw_d, db_d, rise_d, fall_d;

  int cyc;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  ch;
    logic        kind;  // 1 = rise, 0 = fall
  } ev_t;

  ev_t q_e[$];
  ev_t q_d[$];

  always #5 clk = ~clk;

  // cyc tracks the DUT tick counter: tick-driven transitions appear at cyc % 16 == 0
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  multi_debouncer_fsm #(.N_CH(N_CH), .TICK_BITS(4), .N_TICKS(3), .MODE(0)) dut_e (
    .clk(clk), .reset_n(reset_n), .sw(sw_e), .db(db_e), .rise(rise_e), .fall(fall_e)
  );

  multi_debouncer_fsm #(.N_CH(N_CH), .TICK_BITS(4), .N_TICKS(3), .MODE(1)) dut_d (
    .clk(clk), .reset_n(reset_n), .sw(sw_d), .db(db_d), .rise(rise_d), .fall(fall_d)
  );

  task automatic at(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_ev(input bit dly, input int c, input int ch, input logic kind);
    ev_t ev;
    ev.cyc  = c;
    ev.ch   = 8'(ch);
    ev.kind = kind;
    if (dly) q_d.push_back(ev);
    else     q_e.push_back(ev);
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_empty(input string name, input int n);
    n_tests++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected pulses still pending, required 0", name, n);
    end
  endtask

  task automatic pulse(input bit dly, input int ch, input logic kind);
    ev_t got;
    ev_t want;
    got.cyc  = cyc;
    got.ch   = 8'(ch);
    got.kind = kind;
    n_tests++;
    if ((dly ? q_d.size() : q_e.size()) == 0) begin
      n_fail++;
      $display("FAIL pulse_%s: unexpected %s on ch%0d at cyc %0d, required none",
               dly ? "d" : "e", kind ? "rise" : "fall", ch, cyc);
    end else begin
      want = dly ? q_d.pop_front() : q_e.pop_front();
      if (got !== want)
      begin
        n_fail++;
        $display("FAIL pulse_%s: got %s ch%0d cyc %0d, required %s ch%0d cyc %0d",
                 dly ? "d" : "e", got.kind ? "rise" : "fall", got.ch, got.cyc,
                 want.kind ? "rise" : "fall", want.ch, want.cyc);
      end
    end
  endtask

  // Monitor: sample on the falling edge, check exclusivity, pop on every pulse
  always @(negedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      n_tests++;
      if ((rise_e[c] & fall_e[c]) || (rise_d[c] & fall_d[c])) begin
        n_fail++;
        $display("FAIL excl ch%0d: rise_e/fall_e=%b%b rise_d/fall_d=%b%b, required not both",
                 c, rise_e[c], fall_e[c], rise_d[c], fall_d[c]);
      end
      if (rise_e[c] | fall_e[c]) pulse(1'b0, c, rise_e[c]);
      if (rise_d[c] | fall_d[c]) pulse(1'b1, c, rise_d[c]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    sw_e    = '0;
    sw_d    = '0;
    #12;
    chk_vec("rst_db_e",   db_e,   4'b0000);
    chk_vec("rst_rise_e", rise_e, 4'b0000);
    chk_vec("rst_fall_e", fall_e, 4'b0000);
    chk_vec("rst_db_d",   db_d,   4'b0000);
    chk_vec("rst_rise_d", rise_d, 4'b0000);
    chk_vec("rst_fall_d", fall_d, 4'b0000);
    #15;
    reset_n = 1'b1;

    // Early mode: clean press on ch0, then glitches inside the lockout
    at(10);  sw_e[0] = 1'b1; exp_ev(1'b0, 13, 0, 1'b1);
    at(12);  chk_bit("e_ch0_latency", db_e[0], 1'b0);
    at(14);  chk_bit("e_ch0_press",   db_e[0], 1'b1);
    for (int i = 15; i <= 33; i++) begin
      at(i);
      sw_e[0] = i[0];
    end
    at(40);  chk_bit("e_ch0_glitch",  db_e[0], 1'b1);
    at(47);  chk_bit("e_ch0_lock",    db_e[0], 1'b1);
    // Lockout ends at 48; a release afterwards is seen, proving state ONE
    at(50);  sw_e[0] = 1'b0; exp_ev(1'b0, 53, 0, 1'b0);
    at(52);  chk_bit("e_ch0_one",     db_e[0], 1'b1);
    at(54);  chk_bit("e_ch0_release", db_e[0], 1'b0);

    // Early mode: bouncy release on ch1
    at(100); sw_e[1] = 1'b1; exp_ev(1'b0, 103, 1, 1'b1);
    at(150); sw_e[1] = 1'b0; exp_ev(1'b0, 153, 1, 1'b0);
    at(154); sw_e[1] = 1'b1;
    at(156); sw_e[1] = 1'b0;
    at(158); sw_e[1] = 1'b1;
    at(160); sw_e[1] = 1'b0;
    at(170); chk_bit("e_ch1_bounce", db_e[1], 1'b0);
    at(195); chk_bit("e_ch1_settle", db_e[1], 1'b0);

    // Reset in the middle of ch3's rise lockout, sw3 held high across it
    at(200); sw_e[3] = 1'b1; exp_ev(1'b0, 203, 3, 1'b1);
    at(215); chk_bit("e_ch3_lock", db_e[3], 1'b1);
    chk_empty("q_e_before_reset", q_e.size());
    chk_empty("q_d_before_reset", q_d.size());
    reset_n = 1'b0;
    #1;
    chk_vec("mid_rst_db_e",   db_e,   4'b0000);
    chk_vec("mid_rst_fall_e", fall_e, 4'b0000);
    chk_vec("mid_rst_rise_e", rise_e, 4'b0000);
    exp_ev(1'b0, 3, 3, 1'b1);
    #20;
    reset_n = 1'b1;
    at(2);   chk_bit("e_ch3_post_rst_wait", db_e[3], 1'b0);
    at(4);   chk_bit("e_ch3_post_rst",      db_e[3], 1'b1);
    at(50);  chk_bit("e_ch3_one",           db_e[3], 1'b1);

    // Delayed mode: short bounces on ch2 never reach the stability window
    at(60);  sw_d[2] = 1'b1;
    at(70);  sw_d[2] = 1'b0;
    at(75);  sw_d[2] = 1'b1;
    at(90);  sw_d[2] = 1'b0;
    at(95);  chk_bit("d_ch2_bounce", db_d[2], 1'b0);
    at(100); sw_d[2] = 1'b1; exp_ev(1'b1, 144, 2, 1'b1);
    at(140); chk_bit("d_ch2_wait",   db_d[2], 1'b0);
    at(150); chk_bit("d_ch2_stable", db_d[2], 1'b1);

    // Delayed mode: abort on ch0 lands on the cycle that would complete the wait
    at(160); sw_d[0] = 1'b1;
    at(190); chk_bit("d_ch0_wait",  db_d[0], 1'b0);
    at(205); sw_d[0] = 1'b0;
    at(209); chk_bit("d_ch0_abort", db_d[0], 1'b0);
    // Counter must restart from zero: a full three-tick wait again
    at(210); sw_d[0] = 1'b1; exp_ev(1'b1, 256, 0, 1'b1);
    at(250); chk_bit("d_ch0_rewait", db_d[0], 1'b0);
    at(258); chk_bit("d_ch0_rise",   db_d[0], 1'b1);

    // Delayed mode: release on ch2 with one aborted attempt
    at(260); sw_d[2] = 1'b0;
    at(265); chk_bit("d_ch2_fwait", db_d[2], 1'b1);
    at(270); sw_d[2] = 1'b1;
    at(280); sw_d[2] = 1'b0; exp_ev(1'b1, 320, 2, 1'b0);
    at(318); chk_bit("d_ch2_fhold", db_d[2], 1'b1);
    at(322); chk_bit("d_ch2_fall",  db_d[2], 1'b0);

    // Early mode: all channels with skewed edges
    at(330); sw_e[0] = 1'b1; exp_ev(1'b0, 333, 0, 1'b1);
    at(331); sw_e[1] = 1'b1; exp_ev(1'b0, 334, 1, 1'b1);
    at(333); sw_e[2] = 1'b1; exp_ev(1'b0, 336, 2, 1'b1);
    at(336); sw_e[3] = 1'b0; exp_ev(1'b0, 339, 3, 1'b0);
    at(340); chk_vec("e_skew_a", db_e, 4'b0111);
    // ch2 entered lockout on a tick cycle; that tick must not count
    at(370); sw_e[2] = 1'b0; exp_ev(1'b0, 385, 2, 1'b0);
    at(383); chk_vec("e_skew_b", db_e, 4'b0111);
    at(386); chk_vec("e_skew_c", db_e, 4'b0011);
    at(400); sw_e[0] = 1'b0; exp_ev(1'b0, 403, 0, 1'b0);
    at(401); sw_e[1] = 1'b0; exp_ev(1'b0, 404, 1, 1'b0);
    at(403); sw_e[3] = 1'b1; exp_ev(1'b0, 406, 3, 1'b1);
    at(407); chk_vec("e_skew_d", db_e, 4'b1000);
    at(410); sw_e[3] = 1'b0;
    at(412); sw_e[3] = 1'b1;
    at(470); chk_vec("e_skew_e", db_e, 4'b1000);

    at(480);
    chk_empty("q_e_end", q_e.size());
    chk_empty("q_d_end", q_d.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_debouncer_fsm.md
# multi_debouncer_fsm

Parametrised N-channel switch debouncer for the board I/O front end; sits between raw push-button/slide-switch pins and the control logic. Each channel has its own synchroniser and FSM; all channels share one free-running tick generator. A mode parameter selects early response or delayed response. Early response passes the first edge immediately and then ignores glitches. Delayed response passes an edge only after the input has been stable. Both edges are debounced, and one-cycle edge pulses are produced per channel.

## Interface
- N_CH, 4: number of independent channels.
- TICK_BITS, 19: tick period is 2^TICK_BITS clk cycles (~10 ms at 50 MHz).
- N_TICKS, 3: lockout/stability length in ticks; legal range 1..15.
- MODE, 0: 0 = early (react immediately, then lock out); 1 = delayed (react after stable N_TICKS ticks).

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- sw  in  N_CH  raw asynchronous switch inputs.
- db  out  N_CH  debounced levels, registered.
- rise  out  N_CH  one-cycle pulse when db[i] goes 0→1.
- fall  out  N_CH  one-cycle pulse when db[i] goes 1→0.

## Operation
- Synchroniser: two flops per channel. s[i] is sw[i] delayed by 2 cycles, reset to 0.
- Tick generator: TICK_BITS-wide up counter q, reset 0, wraps. m_tick = (q == all-ones), high for one cycle per period.
- Per-channel tick counter cnt: 4 bits, cleared on every state change, incremented on m_tick in the counting states.
- Early mode (MODE=0) states:
  - ZERO (db=0): s=1 → RISE_LOCK.
  - RISE_LOCK (db=1): on m_tick with cnt==N_TICKS-1 → ONE. s is ignored.
  - ONE (db=1): s=0 → FALL_LOCK.
  - FALL_LOCK (db=0): on m_tick with cnt==N_TICKS-1 → ZERO. s is ignored.
- Delayed mode (MODE=1) states:
  - ZERO (db=0): s=1 → RISE_WAIT.
  - RISE_WAIT (db=0): s=0 → ZERO (abort). Otherwise, on m_tick with cnt==N_TICKS-1 → ONE.
  - ONE (db=1): s=0 → FALL_WAIT.
  - FALL_WAIT (db=1): s=1 → ONE (abort). Otherwise, on m_tick with cnt==N_TICKS-1 → ZERO.
- db, rise and fall are registered. They are decoded from the next state and the current state, so the pulse coincides with the first cycle of the new db level.
- Illegal state encoding → ZERO next cycle. db=0, no pulse.
- Channels are fully independent. Only m_tick is shared.

## Timing
- Reset values: db=0, rise=0, fall=0, all states ZERO, q=0, cnt=0, synchroniser flops 0.
- Early-mode latency: sw edge → db change plus pulse = 3 clk cycles (2 sync + 1 FSM register).
- Lockout length: between (N_TICKS-1)·2^TICK_BITS+1 and N_TICKS·2^TICK_BITS cycles. The first tick period is partial.
- Delayed-mode latency: the same window plus 3 cycles, measured from the last input transition.
- m_tick and an abort in the same cycle: the abort wins, and cnt is cleared.
- m_tick in the same cycle as a transition into a counting state: the tick is not counted.
- sw held 1 through reset release: after release, db rises per mode (early: 3 cycles later), with a rise pulse.
- Reset asserted mid-lockout: outputs clear immediately (asynchronously) and no fall pulse is generated.
- rise and fall never assert together for one channel.

## Structure
- Shared package debounce_pkg holds:
  - state encoding constants: ZERO, RISE_LOCK/RISE_WAIT, ONE, FALL_LOCK/FALL_WAIT (3-bit);
  - MODE_EARLY=0 and MODE_DELAYED=1;
  - the cnt width constant (4).
- Sub-module debounce_channel: synchroniser, FSM, cnt and output registers for one channel. It takes MODE and N_TICKS as parameters and m_tick as an input.
- Top: tick generator plus a generate loop of N_CH debounce_channel instances.

## Test plan
Bench uses TICK_BITS=4 (tick every 16 cycles), N_TICKS=3, N_CH=4.
- Early mode, clean press on ch0: db[0]=1 and rise[0] pulse 3 cycles after sw[0]↑. Glitches 0/1 for 20 cycles are ignored. db[0] stays 1 until ≥33 cycles, then ONE.
- Early mode, bouncy release on ch1: db[1]=0 and fall[1] 3 cycles after the first 0. A re-bounce to 1 inside the lockout produces no rise.
- Delayed mode, bounce shorter than 2 ticks on ch2: db[2] stays 0 and no pulse. A stable 1 for 48 cycles → db[2]=1 with a single rise[2].
- Delayed mode, abort coinciding with m_tick: sw drops in the cycle where m_tick fires → state returns to ZERO and cnt=0.
- Reset_n pulsed low while ch3 is in lockout with db=1 → db=0 immediately, no fall pulse. After release with sw held 1 → rise 3 cycles later (early mode).
- All four channels toggled with different skews: each db/rise/fall matches an independent reference model, and rise&fall is never asserted together.
